// File: rtl/dmem_pkg.sv
// Shared types and constants for the DataMemory arbiter.
package dmem_pkg;

  localparam int RAM_SIZE_BIT = 8;
  localparam int DATA_W       = 32;
  localparam int NUM_PORTS    = 2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // An address is illegal if it is not word aligned or points past the last word.
  function automatic logic addr_illegal(input logic [31:0] addr, input int ram_bits);
    logic [31:0] upper;
    upper = addr >> (ram_bits + 2);
    return (upper != 32'd0) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the DataMemory strobe bus.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);

  // port 0: CPU load/store stage
  logic              p0_req;
  logic              p0_we;
  logic [31:0]       p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic              p0_err;
  logic [DATA_W-1:0] p0_rdata;

  // port 1: loader / DMA engine
  logic              p1_req;
  logic              p1_we;
  logic [31:0]       p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic              p1_err;
  logic [DATA_W-1:0] p1_rdata;

  // DataMemory side
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester + memory environment view
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// on contention the port that was not granted last time wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic any_req
);

  import dmem_pkg::*;

  // Winner selection from the current requests and the previous grant
  always_comb begin
    any_req = req0 | req1;
    grant   = PORT_CPU;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = PORT_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port DataMemory.
// Each access takes three cycles: IDLE (sample + latch), ACCESS (memory
// strobes), RESP (one-cycle ack to the winner).
module dmem_arbiter #(
  parameter int RAM_SIZE_BIT = 8,
  parameter int DATA_W       = 32
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  import dmem_pkg::*;

  state_t            state_q;
  state_t            state_d;

  logic              grant;
  logic              any_req;
  logic              last_grant;

  // winner's request fields as seen in IDLE
  logic              win_we;
  logic [31:0]       win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_err;

  // latched request of the access in flight
  logic              lat_id;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_err;

  // per-port response registers
  logic [1:0]        ack_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata_q [2];

  // memory strobes decoded from registered state only
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  rr_arb2 u_rr_arb2 (
    .req0       (bus.p0_req),
    .req1       (bus.p1_req),
    .last_grant (last_grant),
    .grant      (grant),
    .any_req    (any_req)
  );

  // Route the winning port's request fields and classify its address
  always_comb begin
    win_we    = bus.p0_we;
    win_addr  = bus.p0_addr;
    win_wdata = bus.p0_wdata;
    if (grant == PORT_DMA) begin
      win_we    = bus.p1_we;
      win_addr  = bus.p1_addr;
      win_wdata = bus.p1_wdata;
    end
    win_err = addr_illegal(win_addr, RAM_SIZE_BIT);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's request and advance round-robin history in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= PORT_DMA;
      lat_id     <= PORT_CPU;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_err    <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      last_grant <= grant;
      lat_id     <= grant;
      lat_we     <= win_we;
      lat_addr   <= win_addr;
      lat_wdata  <= win_wdata;
      lat_err    <= win_err;
    end
  end

  // Memory strobes: active only in ACCESS, suppressed for illegal addresses
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      mem_write = lat_we && !lat_err;
      mem_read  = !lat_we && !lat_err;
    end
  end

  // Capture the response at the closing edge of ACCESS; ack lives for RESP only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      if (state_q == ACCESS) begin
        ack_q[lat_id]   <= 1'b1;
        err_q[lat_id]   <= lat_err;
        rdata_q[lat_id] <= (lat_we || lat_err) ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  assign bus.p0_ack   = ack_q[0];
  assign bus.p0_err   = err_q[0];
  assign bus.p0_rdata = rdata_q[0];
  assign bus.p1_ack   = ack_q[1];
  assign bus.p1_err   = err_q[1];
  assign bus.p1_rdata = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word DataMemory.
module tb_dmem_arbiter;

  import dmem_pkg::*;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  dmem_arbiter_if #(.DATA_W(32)) bus ();

  dmem_arbiter #(.RAM_SIZE_BIT(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory model: combinational read, write on posedge
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  // Strobe and ack activity counters
  always @(negedge clk) begin
    if (bus.mem_read)  rd_cnt   <= rd_cnt + 1;
    if (bus.mem_write) wr_cnt   <= wr_cnt + 1;
    if (bus.p0_ack)    ack0_cnt <= ack0_cnt + 1;
    if (bus.p1_ack)    ack1_cnt <= ack1_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_ack(input bit port, input int max_cyc, output int cyc, output bit seen);
    cyc = 0; seen = 0;
    while (!seen && cyc < max_cyc) begin
      tick();
      cyc++;
      seen = port ? bus.p1_ack : bus.p0_ack;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    checks++; if ({bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ack_err got %b want 0000", {bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err}); end
    checks++; if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h/%h want 0/0", bus.p0_rdata, bus.p1_rdata); end
    checks++; if ({bus.mem_read, bus.mem_write} !== 2'b00 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus got rd=%b wr=%b a=%h d=%h want all 0", bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata); end
    reset = 1'b1;
    tick();
    checks++; if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_write_read();
    int wr0;
    wr0 = wr_cnt;
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 32'h10; bus.p0_wdata = 32'hDEADBEEF;
    tick();
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
      errors++; $display("FAIL wr_strobe got wr=%b rd=%b want 1/0", bus.mem_write, bus.mem_read); end
    checks++; if (bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_bus got a=%h d=%h want 10/deadbeef", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.p0_ack !== 1'b0) begin
      errors++; $display("FAIL wr_early_ack got %b want 0", bus.p0_ack); end
    tick();
    checks++; if (bus.p0_ack !== 1'b1 || bus.p0_err !== 1'b0) begin
      errors++; $display("FAIL wr_ack got ack=%b err=%b want 1/0", bus.p0_ack, bus.p0_err); end
    checks++; if (bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0) begin
      errors++; $display("FAIL wr_resp_bus got wr=%b a=%h want 0/0", bus.mem_write, bus.mem_addr); end
    bus.p0_we = 0;
    tick();
    checks++; if (bus.p0_ack !== 1'b0 || wr_cnt - wr0 !== 1) begin
      errors++; $display("FAIL wr_once got ack=%b writes=%0d want 0/1", bus.p0_ack, wr_cnt - wr0); end
    tick();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h10) begin
      errors++; $display("FAIL rd_strobe got rd=%b a=%h want 1/10", bus.mem_read, bus.mem_addr); end
    tick();
    checks++; if (bus.p0_ack !== 1'b1 || bus.p0_err !== 1'b0 || bus.p0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data got ack=%b err=%b d=%h want 1/0/deadbeef", bus.p0_ack, bus.p0_err, bus.p0_rdata); end
    bus.p0_req = 0;
    tick(); tick();
    checks++; if (bus.p0_ack !== 1'b0 || bus.mem_read !== 1'b0 || bus.p0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_idle got ack=%b rd=%b d=%h want 0/0/deadbeef", bus.p0_ack, bus.mem_read, bus.p0_rdata); end
  endtask

  task automatic test_contention();
    idle_inputs();
    apply_reset();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h0;
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h4; bus.p1_wdata = 32'h55;
    tick();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0) begin
      errors++; $display("FAIL cont_first got rd=%b wr=%b a=%h want 1/0/0", bus.mem_read, bus.mem_write, bus.mem_addr); end
    tick();
    checks++; if (bus.p0_ack !== 1'b1 || bus.p1_ack !== 1'b0) begin
      errors++; $display("FAIL cont_ack0 got p0=%b p1=%b want 1/0", bus.p0_ack, bus.p1_ack); end
    bus.p0_req = 0;
    tick(); tick();
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h4 || bus.mem_wdata !== 32'h55) begin
      errors++; $display("FAIL cont_p1_wr got wr=%b a=%h d=%h want 1/4/55", bus.mem_write, bus.mem_addr, bus.mem_wdata); end
    tick();
    checks++; if (bus.p1_ack !== 1'b1 || bus.p0_ack !== 1'b0 || bus.p1_err !== 1'b0) begin
      errors++; $display("FAIL cont_ack1 got p1=%b p0=%b err=%b want 1/0/0", bus.p1_ack, bus.p0_ack, bus.p1_err); end
    bus.p1_req = 0;
    bus.p0_req = 1; bus.p0_addr = 32'h4;
    tick(); tick(); tick();
    checks++; if (bus.p0_ack !== 1'b1 || bus.p0_rdata !== 32'h55) begin
      errors++; $display("FAIL cont_readback got ack=%b d=%h want 1/55", bus.p0_ack, bus.p0_rdata); end
    bus.p0_req = 0;
    tick();
  endtask

  task automatic test_fairness();
    int n;
    int t;
    logic exp_port;
    logic [31:0] got_d;
    logic [31:0] exp_d;
    idle_inputs();
    apply_reset();
    bus.p0_req = 1; bus.p0_addr = 32'h10;
    bus.p1_req = 1; bus.p1_addr = 32'h4;
    n = 0; t = 0;
    while (n < 6 && t < 30) begin
      tick();
      t++;
      if (bus.p0_ack || bus.p1_ack) begin
        exp_port = n[0];
        checks++; if (bus.p0_ack !== ~exp_port || bus.p1_ack !== exp_port) begin
          errors++; $display("FAIL fair_order_%0d got p0=%b p1=%b want port %0d", n, bus.p0_ack, bus.p1_ack, exp_port); end
        got_d = exp_port ? bus.p1_rdata : bus.p0_rdata;
        exp_d = exp_port ? 32'h55 : 32'hDEADBEEF;
        checks++; if (got_d !== exp_d) begin
          errors++; $display("FAIL fair_data_%0d got %h want %h", n, got_d, exp_d); end
        n++;
      end
    end
    bus.p0_req = 0; bus.p1_req = 0;
    checks++; if (n !== 6 || t !== 17) begin
      errors++; $display("FAIL fair_timing got acks=%0d cycles=%0d want 6/17", n, t); end
    tick(); tick();
  endtask

  task automatic test_errors();
    int rd0;
    int wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h400; bus.p1_wdata = 32'hAAAA;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h6;
    tick();
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      errors++; $display("FAIL err_strobe0 got rd=%b wr=%b want 0/0", bus.mem_read, bus.mem_write); end
    tick();
    checks++; if (bus.p0_ack !== 1'b1 || bus.p0_err !== 1'b1 || bus.p0_rdata !== 32'h0) begin
      errors++; $display("FAIL err_p0 got ack=%b err=%b d=%h want 1/1/0", bus.p0_ack, bus.p0_err, bus.p0_rdata); end
    bus.p0_req = 0;
    tick(); tick(); tick();
    checks++; if (bus.p1_ack !== 1'b1 || bus.p1_err !== 1'b1 || bus.p1_rdata !== 32'h0) begin
      errors++; $display("FAIL err_p1 got ack=%b err=%b d=%h want 1/1/0", bus.p1_ack, bus.p1_err, bus.p1_rdata); end
    bus.p1_req = 0;
    tick();
    checks++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0 || mem[0] !== 32'h0) begin
      errors++; $display("FAIL err_no_access got rd=%0d wr=%0d mem0=%h want 0/0/0", rd_cnt - rd0, wr_cnt - wr0, mem[0]); end
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 32'h10;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h4;
    tick(); tick();
    checks++; if (bus.p0_ack !== 1'b1 || bus.p1_ack !== 1'b0 || bus.p0_err !== 1'b0) begin
      errors++; $display("FAIL err_rr_advance got p0=%b p1=%b err=%b want 1/0/0", bus.p0_ack, bus.p1_ack, bus.p0_err); end
    bus.p0_req = 0;
    tick(); tick(); tick();
    checks++; if (bus.p1_ack !== 1'b1 || bus.p1_err !== 1'b0 || bus.p1_rdata !== 32'h55) begin
      errors++; $display("FAIL err_recover got ack=%b err=%b d=%h want 1/0/55", bus.p1_ack, bus.p1_err, bus.p1_rdata); end
    bus.p1_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int a0;
    int cyc;
    bit seen;
    a0 = ack0_cnt;
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 32'h20; bus.p0_wdata = 32'h1234;
    tick();
    checks++; if (bus.mem_write !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got wr=%b want 1", bus.mem_write); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0 || dut.state_q !== IDLE) begin
      errors++; $display("FAIL rst_mid_async got wr=%b a=%h st=%0d want 0/0/IDLE", bus.mem_write, bus.mem_addr, dut.state_q); end
    bus.p0_req = 0; bus.p0_we = 0;
    tick();
    reset = 1'b1;
    tick(); tick();
    checks++; if (ack0_cnt - a0 !== 0 || mem[8] !== 32'h0) begin
      errors++; $display("FAIL rst_mid_drop got acks=%0d mem20=%h want 0/0", ack0_cnt - a0, mem[8]); end
    bus.p0_req = 1; bus.p0_addr = 32'h20;
    wait_ack(1'b0, 8, cyc, seen);
    checks++; if (!seen || cyc !== 2 || bus.p0_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid_readback got seen=%b cyc=%0d d=%h want 1/2/0", seen, cyc, bus.p0_rdata); end
    bus.p0_req = 0;
    tick();
  endtask

  task automatic test_req_drop();
    int a1;
    int rd0;
    int cyc;
    bit seen;
    a1 = ack1_cnt; rd0 = rd_cnt;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 32'h10;
    wait_ack(1'b1, 8, cyc, seen);
    checks++; if (!seen || cyc !== 2) begin
      errors++; $display("FAIL drop_first got seen=%b cyc=%0d want 1/2", seen, cyc); end
    bus.p1_req = 0;
    tick(); tick();
    checks++; if (bus.p1_ack !== 1'b0 || dut.state_q !== IDLE) begin
      errors++; $display("FAIL drop_idle got ack=%b st=%0d want 0/IDLE", bus.p1_ack, dut.state_q); end
    bus.p1_req = 1;
    wait_ack(1'b1, 8, cyc, seen);
    checks++; if (!seen || cyc !== 2 || bus.p1_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL drop_second got seen=%b cyc=%0d d=%h want 1/2/deadbeef", seen, cyc, bus.p1_rdata); end
    bus.p1_req = 0;
    tick(); tick(); tick();
    checks++; if (ack1_cnt - a1 !== 2 || rd_cnt - rd0 !== 2) begin
      errors++; $display("FAIL drop_count got acks=%0d reads=%0d want 2/2", ack1_cnt - a1, rd_cnt - rd0); end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_contention();
    test_fairness();
    test_errors();
    test_reset_mid();
    test_req_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 256-word DataMemory.
- Shares the memory between port 0 (CPU load/store stage) and port 1 (loader/DMA engine) using a req/ack handshake.
- Drives the memory's MemRead/MemWrite/Address/Write_data strobes and returns registered read data plus an error flag for illegal addresses.

Parameters:
- RAM_SIZE_BIT, 8, word-index width of the memory; legal byte addresses are 0 .. 4*2^RAM_SIZE_BIT-4, word aligned.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low: state is cleared while reset==0.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  32  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_err  out  1  valid with p0_ack; address illegal, no access performed.
- p0_rdata  out  DATA_W  read data, valid with p0_ack.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0, for port 1.
- mem_read  out  1  to DataMemory MemRead.
- mem_write  out  1  to DataMemory MemWrite.
- mem_addr  out  32  to DataMemory Address.
- mem_wdata  out  DATA_W  to DataMemory Write_data.
- mem_rdata  in  DATA_W  from DataMemory Read_data (combinational).

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset (reset==0) forces IDLE.
- Reset values: all acks/errs 0, rdata 0, last_grant=1 (so port 0 wins first contention), latched request registers 0.
- IDLE (cycle N):
  - If any req is high, pick the winner.
  - Only one requester: it wins.
  - Both requesting: the port != last_grant wins (round robin).
  - Latch winner id, we, addr, wdata, and err = (addr[31:RAM_SIZE_BIT+2]!=0) || (addr[1:0]!=0). Update last_grant. Go to ACCESS.
  - No req: stay in IDLE.
- ACCESS (N+1):
  - mem_addr/mem_wdata are driven from the latched registers.
  - mem_write = latched_we && !err; mem_read = !latched_we && !err.
  - At the closing edge, the write commits in DataMemory and mem_rdata is captured into the winner's rdata register (0 if write or err). Go to RESP.
- RESP (N+2):
  - Winner's ack=1 for exactly one cycle; err=latched err; the loser's ack stays 0. Go to IDLE.
- Latency: ack 2 cycles after the IDLE cycle that sees req. One access per 3 cycles.
- Handshake:
  - The requester keeps req, we, addr and wdata stable until it sees ack.
  - It deasserts req, or presents a new request, the cycle after ack.
  - Requests are sampled only in IDLE; req changes in ACCESS/RESP are ignored.
  - A req held high in IDLE is always a new request.
- Outside ACCESS: mem_read=mem_write=0, mem_addr=0, mem_wdata=0 (registered-state driven, glitch-free).
- rdata registers hold their value until the next completion on that port.
- Fairness: under continuous requests from both ports, grants strictly alternate; no port waits more than one foreign access.
- Error access: no memory strobe is asserted, rdata=0, err=1 with ack; last_grant still advances.
- Reset mid-operation:
  - Asserting reset in ACCESS removes mem_write asynchronously (state→IDLE), so no write commits.
  - A pending ack is dropped. The requester must re-issue after reset release.
- Simultaneous new req on the loser during RESP: served in the next IDLE, since it wins round robin.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - constants RAM_SIZE_BIT=8, DATA_W=32, NUM_PORTS=2, port ids PORT_CPU=0, PORT_DMA=1.
- One sub-module, rr_arb2: combinational 2-way round-robin pick from (req0, req1, last_grant) → grant id + any_req.
- FSM, latches and response registers stay in dmem_arbiter.

Test Plan:
- Port 0 writes 0xDEADBEEF @0x10, then reads 0x10 → mem_write high one cycle in ACCESS with mem_addr=0x10; ack 2 cycles after req; read returns p0_rdata=0xDEADBEEF, p0_err=0.
- Both ports request in the same cycle after reset (p0 read 0x0, p1 write 0x55 @0x4) → port 0 acked first, port 1 acked 3 cycles later; a subsequent read of 0x4 returns 0x55.
- Both ports hold req continuously for 6 accesses → grant order 0,1,0,1,0,1; no port has two consecutive acks.
- Port 1 write to 0x400 (out of range) and port 0 read of 0x6 (misaligned) → ack with err=1, rdata=0, mem_read/mem_write never asserted, memory contents unchanged.
- Reset driven low during ACCESS of a write 0x1234 @0x20 → no ack, FSM in IDLE, read of 0x20 after release returns the prior value (0).
- Req dropped the cycle after ack, then reasserted 2 cycles later → exactly one access per request, no duplicate ack.
